crc6_frame_serializer: RTL and testbench
========================================

// Module: crc6_frame_serializer
// PURPOSE
//  Upstream feeder for the 1-bit CRC-6 engine (poly x^6+x^5+x^3+x^2+x+1, init 6'h3F).
//  - Accepts parallel words over a valid/ready handshake and serializes each frame MSB-first.
//  - Drives the CRC engine one bit per accepted data bit.
//  - Captures the final CRC and appends it as a 6-bit serial trailer.
//  - Output is a framed bit stream with backpressure.
// PARAMETERS
//  DATA_W   8   width of each input word (bits serialized MSB-first)
//  CNT_W    16  width of frames_sent status counter
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous, active-high reset
//  in_data      in   DATA_W  input word
//  in_last      in   1       word is the last of its frame
//  in_valid     in   1       word valid
//  in_ready     out  1       block can accept a word (1-entry holding buffer empty)
//  ser_bit      out  1       serial output bit
//  ser_valid    out  1       ser_bit valid
//  ser_sof      out  1       qualifies first data bit of frame
//  ser_eof      out  1       qualifies last CRC bit of frame
//  ser_ready    in   1       downstream accepts ser_bit this cycle
//  crc_init     out  1       to CRC engine rst: loads 6'h3F
//  crc_en       out  1       to CRC engine enable
//  crc_data     out  1       to CRC engine data_in
//  crc_next     in   6       CRC engine combinational next-state (lfsr_c)
//  frames_sent  out  CNT_W   count of completed frames, wraps
// BEHAVIOUR
//  - Reset: state=IDLE, buffer and shifter empty; frames_sent=0.
//    During reset: in_ready=0, ser_valid=0, ser_sof=0, ser_eof=0, crc_en=0, crc_init=1.
//  - Datapath: 1-entry holding buffer (in_ready = !buf_full) feeds a DATA_W shifter.
//    Accept when in_valid && in_ready.
//  - Buffer and shifter: shifter loads from buffer when shifter is empty or its last bit
//    is accepted this cycle. No bubble while buffer is full.
//  - A "bit transfer" is ser_valid && ser_ready. ser_bit/ser_valid hold stable until transferred.
//  - IDLE:
//    - crc_init=1 and ser_valid=0.
//    - Go to DATA when shifter holds a word; minimum IDLE dwell is 1 cycle.
//  - DATA:
//    - ser_bit = shifter MSB. ser_valid=1 while shifter non-empty.
//    - crc_data=ser_bit. crc_en = bit transfer.
//    - ser_sof=1 on first bit of frame only.
//    - Underrun (shifter empty, no buffered word, frame not ended): ser_valid=0 and crc_en=0
//      until the next word arrives. No error is raised.
//  - DATA -> CRC:
//    - Taken on transfer of last bit of a word tagged in_last.
//    - crc_next is latched into crc_hold on that same cycle; it equals the final CRC.
//  - CRC:
//    - Sends crc_hold[5] down to crc_hold[0], one per transfer. crc_en=0.
//    - ser_eof=1 with bit [0].
//    - On transfer of bit [0]: frames_sent += 1 (wraps to 0), go to IDLE.
//  - Words for the next frame may be buffered during CRC. The first of them waits in the
//    shifter until IDLE completes.
//  - Frame length: any number of words >=1. A 1-word frame yields DATA_W+6 bits.
//  - ser_ready=0 stalls everything. No bits are dropped and no CRC update occurs while stalled.
//  - rst mid-frame: aborts immediately, discards buffered and partial data, and emits no
//    trailer. CRC engine is reinitialized via crc_init.
// CONFIGURATION
//  CRC_INVERT_EN
//    - Defined: trailer bits are transmitted complemented (~crc_hold).
//    - Undefined: crc_hold is sent as-is.
//    - Either way, the CRC engine input and crc_hold contents are unaffected.
// TESTING
//  (bench pairs block with the team 1-bit CRC-6 engine; ser_ready=1 unless stated)
//  1. Single word 8'hA5, in_last=1:
//     - stream 1,0,1,0,0,1,0,1 then trailer 0,0,1,1,1,1 (CRC 6'h0F).
//     - sof on bit0, eof on bit13, frames_sent=1.
//  2. Same with CRC_INVERT_EN: trailer 1,1,0,0,0,0; data bits unchanged.
//  3. Two-word frame 8'hA5,8'h00 presented back-to-back:
//     - 16 data bits contiguous, no bubble.
//     - trailer equals crc_next latched on bit 15; sof once, eof once.
//  4. ser_ready toggled 1/0 every cycle on test 1:
//     - identical bit sequence and CRC 6'h0F.
//     - ser_bit stable while ser_ready=0; crc_en never asserted while ser_ready=0.
//  5. Underrun: second word of frame delayed 5 cycles:
//     - ser_valid=0 and crc_en=0 for the gap; trailer still correct.
//  6. Reset pulse at bit 3 of a frame:
//     - next cycle ser_valid=0 and crc_init=1; no eof; frames_sent unchanged.
//     - following 8'hA5 frame reproduces test 1 exactly.

Source files
------------

// File: rtl/crc6_frame_serializer.sv
// Frame serializer feeding a 1-bit CRC-6 engine: words are buffered, sent MSB-first, and the
// CRC is appended as a 6-bit trailer. Optional macro CRC_INVERT_EN sends the trailer complemented.
module crc6_frame_serializer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              ser_sof,
    output logic              ser_eof,
    input  logic              ser_ready,
    output logic              crc_init,
    output logic              crc_en,
    output logic              crc_data,
    input  logic [5:0]        crc_next,
    output logic [CNT_W-1:0]  frames_sent
);

    localparam int unsigned CRC_W    = 6;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned SH_CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_CRC  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   buf_data_q, buf_data_d;
    logic                buf_last_q, buf_last_d;
    logic                buf_full_q, buf_full_d;
    logic [DATA_W-1:0]   sh_data_q, sh_data_d;
    logic                sh_last_q, sh_last_d;
    logic [SH_CNT_W-1:0] sh_cnt_q, sh_cnt_d;
    logic                sof_pend_q, sof_pend_d;
    logic [CRC_W-1:0]    crc_hold_q, crc_hold_d;
    logic [IDX_W-1:0]    crc_idx_q, crc_idx_d;
    logic [CNT_W-1:0]    frames_q, frames_d;

    logic                in_ready_q, in_ready_d;
    logic                ser_bit_q, ser_bit_d;
    logic                ser_valid_q, ser_valid_d;
    logic                ser_sof_q, ser_sof_d;
    logic                ser_eof_q, ser_eof_d;
    logic                crc_init_q, crc_init_d;
    logic                data_vld_q, data_vld_d;

    logic                xfer;
    logic                accept;
    logic                last_bit_xfer;
    logic                trl_bit;

    // Next-state: buffer/shifter datapath, frame FSM, then output decode of the next state.
    always_comb begin
        state_d       = state_q;
        buf_data_d    = buf_data_q;
        buf_last_d    = buf_last_q;
        buf_full_d    = buf_full_q;
        sh_data_d     = sh_data_q;
        sh_last_d     = sh_last_q;
        sh_cnt_d      = sh_cnt_q;
        sof_pend_d    = sof_pend_q;
        crc_hold_d    = crc_hold_q;
        crc_idx_d     = crc_idx_q;
        frames_d      = frames_q;
        trl_bit       = 1'b0;

        xfer          = ser_valid_q && ser_ready;
        accept        = in_valid && in_ready_q;
        last_bit_xfer = (state_q == S_DATA) && xfer && (sh_cnt_q == SH_CNT_W'(1));

        if ((state_q == S_DATA) && xfer) begin
            sh_data_d  = sh_data_q << 1;
            sh_cnt_d   = sh_cnt_q - SH_CNT_W'(1);
            sof_pend_d = 1'b0;
        end

        // Refill on the same edge the last bit leaves, so back-to-back words have no bubble.
        if (buf_full_q && ((sh_cnt_q == '0) || last_bit_xfer)) begin
            sh_data_d  = buf_data_q;
            sh_last_d  = buf_last_q;
            sh_cnt_d   = SH_CNT_W'(DATA_W);
            buf_full_d = 1'b0;
        end

        if (accept) begin
            buf_data_d = in_data;
            buf_last_d = in_last;
            buf_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (sh_cnt_q != '0) begin
                    state_d    = S_DATA;
                    sof_pend_d = 1'b1;
                end
            end
            S_DATA: begin
                // crc_next already includes the bit transferring now.
                if (last_bit_xfer && sh_last_q) begin
                    state_d    = S_CRC;
                    crc_hold_d = crc_next;
                    crc_idx_d  = IDX_W'(CRC_W - 1);
                end
            end
            S_CRC: begin
                if (xfer) begin
                    if (crc_idx_q == '0) begin
                        state_d  = S_IDLE;
                        frames_d = frames_q + CNT_W'(1);
                    end else begin
                        crc_idx_d = crc_idx_q - IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef CRC_INVERT_EN
        trl_bit = ~crc_hold_d[crc_idx_d];
`else
        trl_bit = crc_hold_d[crc_idx_d];
`endif

        data_vld_d  = (state_d == S_DATA) && (sh_cnt_d != '0);
        ser_valid_d = data_vld_d || (state_d == S_CRC);
        ser_bit_d   = (state_d == S_CRC) ? trl_bit : sh_data_d[DATA_W-1];
        ser_sof_d   = data_vld_d && sof_pend_d;
        ser_eof_d   = (state_d == S_CRC) && (crc_idx_d == '0);
        crc_init_d  = (state_d == S_IDLE);
        in_ready_d  = !buf_full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            buf_data_q  <= '0;
            buf_last_q  <= 1'b0;
            buf_full_q  <= 1'b0;
            sh_data_q   <= '0;
            sh_last_q   <= 1'b0;
            sh_cnt_q    <= '0;
            sof_pend_q  <= 1'b0;
            crc_hold_q  <= '0;
            crc_idx_q   <= '0;
            frames_q    <= '0;
            in_ready_q  <= 1'b0;
            ser_bit_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_sof_q   <= 1'b0;
            ser_eof_q   <= 1'b0;
            crc_init_q  <= 1'b1;
            data_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_data_q  <= buf_data_d;
            buf_last_q  <= buf_last_d;
            buf_full_q  <= buf_full_d;
            sh_data_q   <= sh_data_d;
            sh_last_q   <= sh_last_d;
            sh_cnt_q    <= sh_cnt_d;
            sof_pend_q  <= sof_pend_d;
            crc_hold_q  <= crc_hold_d;
            crc_idx_q   <= crc_idx_d;
            frames_q    <= frames_d;
            in_ready_q  <= in_ready_d;
            ser_bit_q   <= ser_bit_d;
            ser_valid_q <= ser_valid_d;
            ser_sof_q   <= ser_sof_d;
            ser_eof_q   <= ser_eof_d;
            crc_init_q  <= crc_init_d;
            data_vld_q  <= data_vld_d;
        end
    end

    // The engine must advance in the very cycle a data bit is accepted, so enable follows ser_ready.
    assign crc_en      = data_vld_q && ser_ready;
    assign crc_data    = ser_bit_q;
    assign in_ready    = in_ready_q;
    assign ser_bit     = ser_bit_q;
    assign ser_valid   = ser_valid_q;
    assign ser_sof     = ser_sof_q;
    assign ser_eof     = ser_eof_q;
    assign crc_init    = crc_init_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_crc6_frame_serializer.sv
// Bench for crc6_frame_serializer paired with a 1-bit CRC-6 engine; expected stream comes from
// a polynomial long-division model and a bit-queue scoreboard.
module tb_crc6_frame_serializer;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;
`ifdef CRC_INVERT_EN
    localparam logic        INV    = 1'b1;
    localparam logic [13:0] T1_EXP = 14'b10100101_110000;
    localparam logic [21:0] T3_EXP = {16'hA500, 6'b011011};
`else
    localparam logic        INV    = 1'b0;
    localparam logic [13:0] T1_EXP = 14'b10100101_001111;
    localparam logic [21:0] T3_EXP = {16'hA500, 6'b100100};
`endif

    typedef struct packed {
        logic b;
        logic sof;
        logic eof;
        logic trl;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;
    logic              ser_bit;
    logic              ser_valid;
    logic              ser_sof;
    logic              ser_eof;
    logic              ser_ready;
    logic              crc_init;
    logic              crc_en;
    logic              crc_data;
    logic [5:0]        crc_next;
    logic [CNT_W-1:0]  frames_sent;

    int   nerr = 0;
    int   nchk = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    int   exp_frames = 0;
    int   frames_launched = 0;
    exp_t exp_q[$];

    logic [63:0] cap_vec;
    int          cap_n;
    int          cap_cyc [0:63];
    int          cap_sof_at, cap_eof_at, cap_sof_cnt, cap_eof_cnt;

    logic        rst_at_edge = 1'b1;
    logic        hold_v = 1'b0;
    logic [2:0]  hold_bits;

    always #5 clk = ~clk;

    crc6_frame_serializer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready), .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_sof(ser_sof),
        .ser_eof(ser_eof), .ser_ready(ser_ready), .crc_init(crc_init), .crc_en(crc_en),
        .crc_data(crc_data), .crc_next(crc_next), .frames_sent(frames_sent)
    );

    // Team 1-bit CRC-6 engine (poly 0x2F, init 0x3F).
    logic [5:0] lfsr_q;
    always_comb crc_next = {lfsr_q[4:0], 1'b0} ^ ((lfsr_q[5] ^ crc_data) ? 6'h2F : 6'h00);
    always @(posedge clk) begin
        if (crc_init)    lfsr_q <= 6'h3F;
        else if (crc_en) lfsr_q <= crc_next;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // CRC as remainder of (M*x^6 + I*x^n) mod G, by long division over the frame bits.
    function automatic logic [5:0] crc6_ref(input logic [63:0] msg, input int n);
        logic       a [0:69];
        logic [6:0] g;
        logic [5:0] r;
        g = 7'b1101111;
        for (int i = 0; i < 70; i++) a[i] = 1'b0;
        for (int i = 0; i < n; i++) a[i] = msg[n-1-i];
        for (int i = 0; i < 6; i++) a[i] = ~a[i];
        for (int i = 0; i < n; i++)
            if (a[i]) for (int k = 0; k < 7; k++) a[i+k] = a[i+k] ^ g[6-k];
        for (int k = 0; k < 6; k++) r[5-k] = a[n+k];
        return r;
    endfunction

    task automatic push_frame(input logic [63:0] msg, input int n);
        exp_t       e;
        logic [5:0] c;
        c = crc6_ref(msg, n);
        for (int i = 0; i < n; i++) begin
            e.b = msg[n-1-i]; e.sof = (i == 0); e.eof = 1'b0; e.trl = 1'b0;
            exp_q.push_back(e);
        end
        for (int k = 5; k >= 0; k--) begin
            e.b = c[k] ^ INV; e.sof = 1'b0; e.eof = (k == 0); e.trl = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] d, input logic last);
        int   t;
        logic acc;
        t = 0; acc = 1'b0;
        in_data = d; in_last = last; in_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
            if (!acc && t > 2000) begin
                nchk++; nerr++;
                $display("FAIL send_word_timeout: in_ready stayed 0 for %0d cycles", t);
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0][7:0] w, input int nw, input int gap_max);
        logic [63:0] msg;
        msg = '0;
        for (int i = 0; i < nw; i++) msg = {msg[55:0], w[i]};
        push_frame(msg, nw * 8);
        for (int i = 0; i < nw; i++) begin
            send_word(w[i], i == nw - 1);
            if (gap_max > 0) step($urandom_range(gap_max, 0));
        end
        frames_launched++;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        step(2);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        exp_q.delete();
        exp_frames = 0;
        frames_launched = 0;
        rst = 1'b0;
    endtask

    task automatic clear_cap();
        cap_vec = '0; cap_n = 0;
        cap_sof_at = -1; cap_eof_at = -1; cap_sof_cnt = 0; cap_eof_cnt = 0;
    endtask

    always @(posedge clk) rst_at_edge <= rst;

    // Per-cycle compare against the scoreboard queue, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic xf;
        cyc++;
        if (rst_at_edge) begin
            check("reset_outputs", 64'({in_ready, ser_valid, ser_sof, ser_eof, crc_en, crc_init}),
                  64'(6'b000001));
            check("reset_frames", 64'(frames_sent), 64'd0);
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                check("stall_stable", 64'({ser_valid, ser_bit, ser_sof, ser_eof}),
                      64'({1'b1, hold_bits}));
            check("frames_sent", 64'(frames_sent), 64'(exp_frames));
            xf = ser_valid && ser_ready;
            if (xf) begin
                if (exp_q.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL unexpected_bit: got bit %0b with nothing expected (cycle %0d)",
                             ser_bit, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("bit_sof_eof", 64'({ser_bit, ser_sof, ser_eof}), 64'({e.b, e.sof, e.eof}));
                    check("crc_en_xfer", 64'(crc_en), 64'(!e.trl));
                    if (e.eof) exp_frames++;
                end
                if (cap_n < 64) cap_cyc[cap_n] = cyc;
                cap_vec = {cap_vec[62:0], ser_bit};
                if (ser_sof) begin cap_sof_at = cap_n; cap_sof_cnt++; end
                if (ser_eof) begin cap_eof_at = cap_n; cap_eof_cnt++; end
                cap_n++;
            end else begin
                check("crc_en_no_xfer", 64'(crc_en), 64'd0);
            end
            hold_v    = ser_valid && !ser_ready;
            hold_bits = {ser_bit, ser_sof, ser_eof};
        end
    end

    initial begin
        ser_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       ser_ready = 1'b1;
                1:       ser_ready = ~ser_ready;
                default: ser_ready = ($urandom_range(99, 0) < 70);
            endcase
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][7:0] w;
        int              t;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        clear_cap();

        check("model_crc_A5", 64'(crc6_ref(64'hA5, 8)), 64'h0F);
        check("model_crc_A500", 64'(crc6_ref(64'hA500, 16)), 64'h24);

        do_reset(2);

        // Single-word frame.
        clear_cap();
        send_frame({8'h00, 8'h00, 8'h00, 8'hA5}, 1, 0);
        wait_drain("t1_drain", 200);
        check("t1_count", 64'(cap_n), 64'd14);
        check("t1_stream", 64'(cap_vec[13:0]), 64'(T1_EXP));
        check("t1_sof_eof", 64'({8'(cap_sof_at), 8'(cap_eof_at)}), 64'({8'd0, 8'd13}));
        check("t1_frames", 64'(frames_sent), 64'd1);

        // Two words back-to-back.
        clear_cap();
        send_frame({8'h00, 8'h00, 8'h00, 8'hA5}, 2, 0);
        wait_drain("t3_drain", 200);
        check("t3_stream", 64'(cap_vec[21:0]), 64'(T3_EXP));
        check("t3_contiguous", 64'(cap_cyc[15] - cap_cyc[0]), 64'd15);
        check("t3_sof_eof_cnt", 64'({8'(cap_sof_cnt), 8'(cap_eof_cnt)}), 64'({8'd1, 8'd1}));

        // ser_ready toggling every cycle.
        rdy_mode = 1;
        clear_cap();
        send_frame({8'h00, 8'h00, 8'h00, 8'hA5}, 1, 0);
        wait_drain("t4_drain", 400);
        rdy_mode = 0;
        step(2);
        check("t4_stream", 64'(cap_vec[13:0]), 64'(T1_EXP));
        check("t4_frames", 64'(frames_sent), 64'd3);

        // Underrun between words.
        clear_cap();
        push_frame(64'hA53C, 16);
        send_word(8'hA5, 1'b0);
        step(14);
        send_word(8'h3C, 1'b1);
        frames_launched++;
        wait_drain("t5_drain", 200);
        check("t5_gap", 64'((cap_cyc[8] - cap_cyc[7]) >= 5), 64'd1);
        check("t5_count", 64'(cap_n), 64'd22);

        // Reset at bit 3 of a frame, then a clean frame.
        do_reset(2);
        clear_cap();
        push_frame(64'hA5, 8);
        send_word(8'hA5, 1'b1);
        t = 0;
        while (cap_n < 3 && t < 200) begin @(posedge clk); t++; end
        #1;
        check("t6_reached_bit3", 64'(cap_n), 64'd3);
        do_reset(1);
        step(4);
        check("t6_no_eof", 64'(cap_eof_cnt), 64'd0);
        check("t6_frames", 64'(frames_sent), 64'd0);
        clear_cap();
        send_frame({8'h00, 8'h00, 8'h00, 8'hA5}, 1, 0);
        wait_drain("t6_drain", 200);
        check("t6_stream", 64'(cap_vec[13:0]), 64'(T1_EXP));
        check("t6_frames_after", 64'(frames_sent), 64'd1);

        // Random frames, random gaps and backpressure.
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
            send_frame(w, $urandom_range(4, 1), 2);
        end
        wait_drain("rand_drain", 6000);
        rdy_mode = 0;
        step(2);
        check("rand_frames", 64'(frames_sent), 64'(frames_launched));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
